// File: rtl/gb_apu_pkg.sv
// rtl/gb_apu_pkg.sv - shared APU types and constants for the channel 1 sweep unit
// Contents:
//   sweep_state_t        sweep sequencer states
//   MAX_FREQ             largest frequency that fits the period register
//   NR10_* constants     bit positions of the NR10 fields {period, negate, shift}
package gb_apu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRIG_CHK = 2'd1,
        STEP_WR  = 2'd2,
        STEP_CHK = 2'd3
    } sweep_state_t;

    localparam logic [10:0] MAX_FREQ = 11'd2047;

    localparam int NR10_PERIOD_MSB = 6;
    localparam int NR10_PERIOD_LSB = 4;
    localparam int NR10_NEGATE_BIT = 3;
    localparam int NR10_SHIFT_MSB  = 2;
    localparam int NR10_SHIFT_LSB  = 0;

endpackage

// File: rtl/gb_sweep_calc.sv
// rtl/gb_sweep_calc.sv - combinational sweep step: shadow +/- (shadow >> shift)
// Ports:
//   shadow    in   current shadow frequency
//   shift     in   NR10 shift field
//   negate    in   NR10 negate bit (1 = subtract)
//   result    out  low FREQ_W bits of the new frequency
//   overflow  out  add-mode result exceeds MAX_FREQ
module gb_sweep_calc #(
    parameter int FREQ_W = 11
) (
    input  logic [FREQ_W-1:0] shadow,
    input  logic [2:0]        shift,
    input  logic              negate,
    output logic [FREQ_W-1:0] result,
    output logic              overflow
);
    import gb_apu_pkg::*;

    logic [FREQ_W-1:0] delta;
    logic [FREQ_W:0]   sum;

    always_comb begin
        delta = shadow >> shift;
        // delta never exceeds shadow, so the subtraction cannot wrap
        if (negate) begin
            sum = {1'b0, shadow} - {1'b0, delta};
        end else begin
            sum = {1'b0, shadow} + {1'b0, delta};
        end
        overflow = !negate && (sum > (FREQ_W + 1)'(MAX_FREQ));
        result   = sum[FREQ_W-1:0];
    end

endmodule

// File: rtl/gb_freq_sweep.sv
// rtl/gb_freq_sweep.sv - channel 1 frequency sweep controller
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   sweep_clk    in   128 Hz one-cycle tick from the frame sequencer
//   trigger      in   one-cycle channel 1 trigger pulse
//   nr10         in   live NR10 {period[6:4], negate[3], shift[2:0]}
//   freq_in      in   channel frequency, sampled on trigger
//   freq_out     out  swept frequency to write back
//   freq_update  out  one-cycle pulse: channel loads freq_out
//   ch_disable   out  one-cycle pulse: channel must disable
//   busy         out  sequencer not idle
module gb_freq_sweep #(
    parameter int FREQ_W             = 11,
    parameter int ZERO_PERIOD_RELOAD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sweep_clk,
    input  logic              trigger,
    input  logic [6:0]        nr10,
    input  logic [FREQ_W-1:0] freq_in,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_update,
    output logic              ch_disable,
    output logic              busy
);
    import gb_apu_pkg::*;

    // Timer must hold both the 3-bit period and the zero-period reload value
    localparam int RELOAD_W = $clog2(ZERO_PERIOD_RELOAD + 1);
    localparam int TIMER_W  = (RELOAD_W > 3) ? RELOAD_W : 3;

    sweep_state_t      state_q, state_d;
    logic [FREQ_W-1:0] shadow_q, shadow_d;
    logic [FREQ_W-1:0] freq_out_q, freq_out_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic              sweep_en_q, sweep_en_d;
    logic              neg_used_q, neg_used_d;
    logic              pending_q, pending_d;
    logic              freq_update_q, freq_update_d;
    logic              ch_disable_q, ch_disable_d;

    logic [2:0]        period;
    logic [2:0]        shift;
    logic              negate;
    logic [TIMER_W-1:0] reload_val;
    logic [TIMER_W-1:0] timer_dec;
    logic [FREQ_W-1:0] calc_result;
    logic              calc_overflow;

    assign period = nr10[NR10_PERIOD_MSB:NR10_PERIOD_LSB];
    assign negate = nr10[NR10_NEGATE_BIT];
    assign shift  = nr10[NR10_SHIFT_MSB:NR10_SHIFT_LSB];

    assign reload_val = (period == 3'd0) ? TIMER_W'(ZERO_PERIOD_RELOAD) : TIMER_W'(period);
    assign timer_dec  = (timer_q != '0) ? (timer_q - 1'b1) : '0;

    gb_sweep_calc #(
        .FREQ_W (FREQ_W)
    ) u_calc (
        .shadow   (shadow_q),
        .shift    (shift),
        .negate   (negate),
        .result   (calc_result),
        .overflow (calc_overflow)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        freq_out_d    = freq_out_q;
        timer_d       = timer_q;
        sweep_en_d    = sweep_en_q;
        neg_used_d    = neg_used_q;
        pending_d     = pending_q;
        freq_update_d = 1'b0;
        ch_disable_d  = 1'b0;

        // Leaving negate mode after a negate calculation kills the channel
        if (neg_used_q && !negate) begin
            ch_disable_d = 1'b1;
            neg_used_d   = 1'b0;
        end

        if (trigger) begin
            // Trigger restarts everything, discarding any in-flight step or tick
            shadow_d   = freq_in;
            freq_out_d = freq_in;
            timer_d    = reload_val;
            sweep_en_d = (period != 3'd0) || (shift != 3'd0);
            neg_used_d = 1'b0;
            pending_d  = 1'b0;
            state_d    = (shift != 3'd0) ? TRIG_CHK : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sweep_clk || pending_q) begin
                        pending_d = 1'b0;
                        if (timer_dec == '0) begin
                            timer_d = reload_val;
                            if (sweep_en_q && (period != 3'd0)) begin
                                state_d = STEP_WR;
                            end
                        end else begin
                            timer_d = timer_dec;
                        end
                    end
                end
                TRIG_CHK: begin
                    if (sweep_clk) begin
                        pending_d = 1'b1;
                    end
                    if (calc_overflow) begin
                        ch_disable_d = 1'b1;
                    end
                    if (negate) begin
                        neg_used_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                STEP_WR: begin
                    if (sweep_clk) begin
                        pending_d = 1'b1;
                    end
                    if (calc_overflow) begin
                        ch_disable_d = 1'b1;
                        state_d      = IDLE;
                    end else if (shift != 3'd0) begin
                        shadow_d      = calc_result;
                        freq_out_d    = calc_result;
                        freq_update_d = 1'b1;
                        if (negate) begin
                            neg_used_d = 1'b1;
                        end
                        state_d = STEP_CHK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                STEP_CHK: begin
                    if (sweep_clk) begin
                        pending_d = 1'b1;
                    end
                    if (calc_overflow) begin
                        ch_disable_d = 1'b1;
                    end
                    if (negate) begin
                        neg_used_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            freq_out_q    <= '0;
            timer_q       <= '0;
            sweep_en_q    <= 1'b0;
            neg_used_q    <= 1'b0;
            pending_q     <= 1'b0;
            freq_update_q <= 1'b0;
            ch_disable_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            freq_out_q    <= freq_out_d;
            timer_q       <= timer_d;
            sweep_en_q    <= sweep_en_d;
            neg_used_q    <= neg_used_d;
            pending_q     <= pending_d;
            freq_update_q <= freq_update_d;
            ch_disable_q  <= ch_disable_d;
        end
    end

    assign freq_out    = freq_out_q;
    assign freq_update = freq_update_q;
    assign ch_disable  = ch_disable_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gb_freq_sweep.sv
// tb/tb_gb_freq_sweep.sv - scoreboard bench for gb_freq_sweep
module tb_gb_freq_sweep;

    logic        clk = 1'b0;
    logic        reset;
    logic        sweep_clk;
    logic        trigger;
    logic [6:0]  nr10;
    logic [10:0] freq_in;
    logic [10:0] freq_out;
    logic        freq_update;
    logic        ch_disable;
    logic        busy;

    gb_freq_sweep #(
        .FREQ_W             (11),
        .ZERO_PERIOD_RELOAD (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sweep_clk   (sweep_clk),
        .trigger     (trigger),
        .nr10        (nr10),
        .freq_in     (freq_in),
        .freq_out    (freq_out),
        .freq_update (freq_update),
        .ch_disable  (ch_disable),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected output pulses, tagged with the cycle in which they must be visible
    typedef struct {
        int          cyc;
        logic        upd;
        logic        dis;
        logic [10:0] fout;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: trigger/tick decisions schedule a future calculation job
    int          job_cyc;
    bit          job_is_step;
    logic [10:0] m_shadow, m_fout, m_fout_vis;
    int          m_timer;
    bit          m_en, m_neg, m_pend, m_busy;

    function automatic void sweep_calc(input logic [10:0] sh, input logic [6:0] r,
                                       output int res, output bit ovf);
        int d;
        d   = int'(sh) >> r[2:0];
        res = r[3] ? int'(sh) - d : int'(sh) + d;
        ovf = !r[3] && (res > 2047);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        job_cyc    = -1;
        job_is_step = 0;
        m_shadow   = 0;
        m_fout     = 0;
        m_fout_vis = 0;
        m_timer    = 0;
        m_en       = 0;
        m_neg      = 0;
        m_pend     = 0;
        m_busy     = 0;
    endfunction

    function automatic void model_cycle(input int n, input bit t, input bit s,
                                        input logic [6:0] r, input logic [10:0] f);
        int period, shift, res, reload;
        bit neg, ovf, upd, dis;
        period = int'(r[6:4]);
        shift  = int'(r[2:0]);
        neg    = r[3];
        reload = (period == 0) ? 8 : period;
        upd = 0;
        dis = 0;
        m_fout_vis = m_fout;
        m_busy = (job_cyc == n);
        if (m_neg && !neg) begin
            dis   = 1;
            m_neg = 0;
        end
        if (t) begin
            job_cyc  = -1;
            m_pend   = 0;
            m_shadow = f;
            m_fout   = f;
            m_timer  = reload;
            m_en     = (period != 0) || (shift != 0);
            m_neg    = 0;
            if (shift != 0) begin
                job_cyc     = n + 1;
                job_is_step = 0;
            end
        end else if (m_busy) begin
            if (s) m_pend = 1;
            sweep_calc(m_shadow, r, res, ovf);
            job_cyc = -1;
            if (!job_is_step) begin
                if (ovf) dis = 1;
                if (neg) m_neg = 1;
            end else if (ovf) begin
                dis = 1;
            end else if (shift != 0) begin
                m_shadow = 11'(res);
                m_fout   = 11'(res);
                upd      = 1;
                if (neg) m_neg = 1;
                job_cyc     = n + 1;
                job_is_step = 0;
            end
        end else if (s || m_pend) begin
            m_pend = 0;
            if (m_timer > 0) m_timer--;
            if (m_timer == 0) begin
                m_timer = reload;
                if (m_en && period != 0) begin
                    job_cyc     = n + 1;
                    job_is_step = 1;
                end
            end
        end
        if (upd || dis) exp_q.push_back('{n + 1, upd, dis, m_fout});
    endfunction

    logic [6:0]  cur_nr10 = 7'h00;
    logic [10:0] cur_fin  = 11'd0;

    task automatic step(input bit t, input bit s, input logic [6:0] r, input logic [10:0] f);
        @(posedge clk);
        #1;
        cur_nr10  = r;
        cur_fin   = f;
        trigger   = t;
        sweep_clk = s;
        nr10      = r;
        freq_in   = f;
        model_cycle(cyc, t, s, r, f);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, cur_nr10, cur_fin);
    endtask

    // Monitor: compares every driven cycle against the model and the pulse queue
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("freq_out", int'(freq_out), int'(m_fout_vis));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_pulse_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (freq_update || ch_disable) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    chk("sb_freq_update", int'(freq_update), int'(exp_q[0].upd));
                    chk("sb_ch_disable", int'(ch_disable), int'(exp_q[0].dis));
                    chk("sb_freq_out", int'(freq_out), int'(exp_q[0].fout));
                    void'(exp_q.pop_front());
                end else begin
                    chk("unexpected_pulse", int'({freq_update, ch_disable}), 0);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("missing_pulse", 0, int'({exp_q[0].upd, exp_q[0].dis}));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b0;
        trigger   = 1'b0;
        sweep_clk = 1'b0;
        nr10      = 7'h00;
        freq_in   = 11'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_freq_out", int'(freq_out), 0);
        chk("rst_freq_update", int'(freq_update), 0);
        chk("rst_ch_disable", int'(ch_disable), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        mon_en = 1;
        idle(2);

        // Reset asserted while the step write is in flight
        step(1, 0, 7'h11, 11'd100);
        idle(2);
        step(0, 1, 7'h11, 11'd100);
        @(posedge clk);
        #2;
        mon_en = 0;
        chk("mid_busy_before_reset", int'(busy), 1);
        trigger   = 1'b0;
        sweep_clk = 1'b0;
        reset     = 1'b0;
        #1;
        chk("mid_rst_freq_out", int'(freq_out), 0);
        chk("mid_rst_freq_update", int'(freq_update), 0);
        chk("mid_rst_ch_disable", int'(ch_disable), 0);
        chk("mid_rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle(1);
        mon_en = 1;
        idle(5);

        // Add mode: 1024 -> 1536, follow-up check overflows at 2304
        step(1, 0, 7'h21, 11'd1024);
        idle(2);
        chk("t2_no_disable", int'(ch_disable), 0);
        step(0, 1, 7'h21, 11'd1024);
        idle(1);
        step(0, 1, 7'h21, 11'd1024);
        idle(2);
        chk("t2_freq_update", int'(freq_update), 1);
        chk("t2_freq_out", int'(freq_out), 1536);
        idle(1);
        chk("t2_ch_disable", int'(ch_disable), 1);
        idle(3);

        // Trigger-time overflow: 2000 + 1000
        step(1, 0, 7'h11, 11'd2000);
        idle(2);
        chk("t3_ch_disable", int'(ch_disable), 1);
        chk("t3_freq_out", int'(freq_out), 2000);
        idle(3);

        // Negate mode step then leaving negate mode
        step(1, 0, 7'h1A, 11'd1000);
        idle(2);
        step(0, 1, 7'h1A, 11'd1000);
        idle(2);
        chk("t4_freq_update", int'(freq_update), 1);
        chk("t4_freq_out", int'(freq_out), 750);
        idle(2);
        chk("t4_no_disable_yet", int'(ch_disable), 0);
        step(0, 0, 7'h12, 11'd1000);
        idle(1);
        chk("t4_quirk_disable", int'(ch_disable), 1);
        idle(3);

        // Period 0: ticks never step; shift 0 trigger never busy
        step(1, 0, 7'h03, 11'd800);
        idle(2);
        chk("t5_no_disable", int'(ch_disable), 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 7'h03, 11'd800);
            idle(1);
            chk("t5_no_update", int'(freq_update), 0);
        end
        step(1, 0, 7'h00, 11'd500);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("t5_never_busy", int'(busy), 0);
        end

        // Trigger and tick together with timer at 1: tick discarded
        step(1, 0, 7'h11, 11'd300);
        idle(3);
        step(1, 1, 7'h11, 11'd300);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("t6_no_update", int'(freq_update), 0);
        end

        // Tick during trigger check is deferred to the next idle cycle
        step(1, 0, 7'h11, 11'd300);
        step(0, 1, 7'h11, 11'd300);
        chk("t7_busy_trig_chk", int'(busy), 1);
        idle(1);
        chk("t7_idle_pending", int'(busy), 0);
        idle(2);
        chk("t7_freq_update", int'(freq_update), 1);
        chk("t7_freq_out", int'(freq_out), 450);
        idle(4);

        // Randomised traffic against the model
        for (int i = 0; i < 2500; i++) begin
            bit t, s;
            logic [6:0] r;
            logic [10:0] f;
            t = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 5) == 0);
            r = cur_nr10;
            if ($urandom_range(0, 24) == 0) r = 7'($urandom);
            f = ($urandom_range(0, 1) == 0) ? 11'($urandom) : 11'($urandom_range(1400, 2047));
            step(t, s, r, f);
        end
        idle(10);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_freq_sweep.md
Name: gb_freq_sweep

Overview:
- Channel 1 frequency-sweep controller for the APU.
- Consumes the 128 Hz sweep tick from the frame sequencer and the NR10 sweep register.
- Sequences shadow-frequency recalculation and overflow checks, writes the swept frequency back to the channel, and requests channel disable on overflow or on the negate-mode quirk.
- Sits between the frame sequencer / register file and the channel 1 period divider.

Parameters:
- FREQ_W, 11: frequency (period) register width.
- ZERO_PERIOD_RELOAD, 8: timer reload value used when the NR10 period field is 0.

Ports:
- clk  in  1  base system clock, 2^22 Hz.
- reset  in  1  asynchronous, active-low reset.
- sweep_clk  in  1  one-cycle sweep tick from the frame sequencer (128 Hz).
- trigger  in  1  one-cycle channel 1 trigger pulse (NR14 bit 7 write).
- nr10  in  7  {period[6:4], negate[3], shift[2:0]}, live register value.
- freq_in  in  FREQ_W  current NR13/NR14 frequency, sampled on trigger.
- freq_out  out  FREQ_W  swept frequency to write back.
- freq_update  out  1  one-cycle pulse; channel loads freq_out.
- ch_disable  out  1  one-cycle pulse; channel must disable.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, shadow=0, timer=0, sweep_en=0, neg_used=0, pending=0. Outputs freq_out=0, freq_update=0, ch_disable=0, busy=0.
- Calc function: delta = shadow >> shift; result computed 12 bits wide.
  - Add mode: result = shadow + delta; overflow when result > 2047.
  - Negate mode: result = shadow - delta; never overflows; sets neg_used=1 when the result is used.
- FSM states: IDLE, TRIG_CHK, STEP_WR, STEP_CHK.
- Trigger accepted in IDLE or any other state; it aborts an in-flight step and clears pending. Same cycle:
  - shadow<=freq_in, freq_out<=freq_in.
  - timer<=(period==0 ? ZERO_PERIOD_RELOAD : period).
  - sweep_en<=(period!=0 || shift!=0).
  - neg_used<=0.
  - Next state: TRIG_CHK if shift!=0, else IDLE.
- TRIG_CHK: compute calc. If overflow, pulse ch_disable. Shadow and freq_out are not written. Return to IDLE.
- sweep_clk in IDLE without trigger:
  - If timer>0, timer decrements.
  - If the decremented value is 0 or timer was already 0: timer reloads (period or ZERO_PERIOD_RELOAD).
  - If sweep_en and period!=0, go to STEP_WR.
- STEP_WR: compute calc.
  - Overflow: pulse ch_disable, go to IDLE.
  - Else if shift!=0: shadow<=result, freq_out<=result, pulse freq_update, go to STEP_CHK.
  - Else (shift==0): go to IDLE.
- STEP_CHK: recompute calc on the new shadow. Overflow pulses ch_disable; no write. Return to IDLE.
- Latency:
  - Trigger -> ch_disable: 2 cycles after the trigger edge.
  - Step tick -> freq_update: 2 cycles.
  - Step tick -> follow-up ch_disable: 3 cycles.
- Trigger and sweep_clk in the same cycle: trigger wins; the tick is discarded.
- sweep_clk while busy and no trigger: pending<=1; processed on the first IDLE cycle as if it arrived then.
- Negate quirk: in any cycle with neg_used=1 and nr10[3]==0, pulse ch_disable once and clear neg_used.
- Only one ch_disable pulse per cycle; the quirk and overflow pulses OR together.
- nr10 is read live at every use. Timer reload uses the current period field.
- busy is combinational from state (state != IDLE).

Decomposition:
- Shared package gb_apu_pkg:
  - typedef sweep_state_t (enum IDLE, TRIG_CHK, STEP_WR, STEP_CHK).
  - localparam MAX_FREQ=11'd2047.
  - NR10 field-slice constants.
- Sub-module gb_sweep_calc: combinational; inputs shadow, shift, negate; outputs result[FREQ_W-1:0] and overflow.

Test Plan:
- Reset mid-step: reset low while in STEP_WR -> all outputs 0 and busy=0 immediately (async), no pulse after release.
- nr10=0x21 (period 2, add, shift 1), freq_in=1024, trigger:
  - no ch_disable (check result 1536).
  - after 2 sweep_clk: freq_out=1536 with freq_update pulse.
  - next cycle ch_disable=1 (2304>2047).
- nr10=0x11, freq_in=2000, trigger -> ch_disable pulse 2 cycles later (3000 overflow); freq_out stays 2000.
- nr10=0x1A (period 1, negate, shift 2), freq_in=1000, trigger, 1 sweep_clk:
  - freq_out=750 with freq_update.
  - then write nr10=0x12 -> ch_disable pulse next cycle.
- nr10=0x03 (period 0, shift 3), freq_in=800, trigger:
  - TRIG_CHK runs with no disable (result 900).
  - 20 sweep_clk -> no freq_update.
  - nr10=0x00 trigger -> busy never asserts.
- Trigger and sweep_clk asserted the same cycle with timer=1 -> timer reloads from trigger, no STEP_WR.
- sweep_clk during TRIG_CHK -> processed next IDLE cycle (freq_update 2 cycles later when due).
